// File: rtl/sr_latch_bank.sv
// Bank of CHANNELS clocked set/reset latches with configurable S=R=1 resolution.
// Optional minimum-hold timer per channel is compiled in with SR_LATCH_BANK_HOLD_EN.
module sr_latch_bank #(
  parameter int CHANNELS    = 4,
  parameter int MODE        = 0,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] S,
  input  logic [CHANNELS-1:0] R,
  input  logic [CHANNELS-1:0] clr_conflict,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] Qn,
  output logic [CHANNELS-1:0] conflict,
  output logic [CHANNELS-1:0] hold_active
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_latch_bank: MODE must be 0..3");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("sr_latch_bank: HOLD_CYCLES must be >= 1");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("sr_latch_bank: CHANNELS must be 1..32");
  end

  function automatic logic resolve(input logic s, input logic r, input logic q);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (MODE)
          0:       nxt = 1'b0;
          1:       nxt = 1'b1;
          2:       nxt = q;
          default: nxt = ~q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] upd;
  logic [CHANNELS-1:0] q_next;

  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      req[i] = resolve(S[i], R[i], Q[i]);
    end
  end

`ifdef SR_LATCH_BANK_HOLD_EN
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt [CHANNELS];

  // Hold counter: a running count blocks updates; a permitted change reloads it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (cnt[i] != '0) begin
        cnt[i] <= cnt[i] - 1'b1;
      end else if (req[i] != Q[i]) begin
        cnt[i] <= LOAD;
      end
    end
  end

  always_comb begin
    hold_active = '0;
    upd         = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hold_active[i] = (cnt[i] != '0);
      upd[i]         = (cnt[i] == '0) && (req[i] != Q[i]);
    end
  end
`else
  assign hold_active = '0;
  assign upd         = req ^ Q;
`endif

  assign q_next = (Q & ~upd) | (req & upd);

  always_ff @(posedge clk) begin
    if (rst) begin
      Q        <= '0;
      Qn       <= '1;
      conflict <= '0;
    end else begin
      Q        <= q_next;
      Qn       <= ~q_next;
      // a new S=R=1 event outranks a clear on the same edge
      conflict <= (conflict & ~clr_conflict) | (S & R);
    end
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank: one instance per MODE (0..3) sharing stimulus.
// Hold-timer steps are selected when SR_LATCH_BANK_HOLD_EN is defined.
module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] S, R, clr;
  logic [3:0] q  [4];
  logic [3:0] qn [4];
  logic [3:0] cf [4];
  logic [3:0] ha [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_latch_bank #(
      .CHANNELS(4),
      .MODE(m),
      .HOLD_CYCLES(8)
    ) dut (
      .clk(clk),
      .rst(rst),
      .S(S),
      .R(R),
      .clr_conflict(clr),
      .Q(q[m]),
      .Qn(qn[m]),
      .conflict(cf[m]),
      .hold_active(ha[m])
    );
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp3 [4];
    logic [3:0] expi [4];

    rst = 1'b1; S = '0; R = '0; clr = '0;
    repeat (2) tick();
    for (int m = 0; m < 4; m++) begin
      chk("rst_q", q[m], 4'b0000);
      chk("rst_qn", qn[m], 4'b1111);
      chk("rst_conflict", cf[m], 4'b0000);
      chk("rst_hold", ha[m], 4'b0000);
    end
    rst = 1'b0;

    // sticky conflict flag
    S = 4'b0001; R = 4'b0001;
    tick();
    chk("conflict_set_m0", cf[0], 4'b0001);
    chk("conflict_set_m2", cf[2], 4'b0001);
    chk("conflict_m0_q", q[0], 4'b0000);
    S = '0; R = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("conflict_sticky", cf[0], 4'b0001);
    end
    clr = 4'b0001; S = 4'b0001; R = 4'b0001;
    tick();
    chk("clr_with_sr", cf[0], 4'b0001);
    S = '0; R = '0;
    tick();
    chk("clr_alone", cf[0], 4'b0000);
    chk("clr_alone_m1", cf[1], 4'b0000);
    clr = '0;

`ifdef SR_LATCH_BANK_HOLD_EN
    S = 4'b0001;
    tick();
    chk("hold_set_q", q[0], 4'b0001);
    chk("hold_set_active", ha[0], 4'b0001);
    S = '0; R = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("hold_q_stable", q[0], 4'b0001);
      chk("hold_active_run", ha[0], (k < 7) ? 4'b0001 : 4'b0000);
    end
    tick();
    chk("hold_release_q", q[0], 4'b0000);
    chk("hold_release_qn", qn[0], 4'b1111);
    R = '0;
    repeat (7) tick();
    S = 4'b0001;
    tick();
    chk("hold_set2_q", q[0], 4'b0001);
    S = '0; R = 4'b0001;
    tick();
    R = '0;
    chk("hold_drop_pulse", q[0], 4'b0001);
    repeat (10) tick();
    chk("hold_drop_later", q[0], 4'b0001);
    chk("hold_idle_active", ha[0], 4'b0000);
    R = 4'b0001;
    tick();
    R = '0;
    chk("hold_clear_q", q[0], 4'b0000);
    repeat (7) tick();
    S = 4'b0001;
    tick();
    S = '0;
    chk("midhold_pre_q", q[0], 4'b0001);
    chk("midhold_pre_active", ha[0], 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midhold_rst_q", q[0], 4'b0000);
    chk("midhold_rst_active", ha[0], 4'b0000);
    S = 4'b0001;
    tick();
    S = '0;
    chk("midhold_set_after", q[0], 4'b0001);
`else
    S = 4'b0001;
    tick();
    chk("set_q", q[0], 4'b0001);
    chk("set_qn", qn[0], 4'b1110);
    chk("set_no_hold", ha[0], 4'b0000);
    S = '0; R = 4'b0001;
    tick();
    for (int m = 0; m < 4; m++) chk("reset_q", q[m], 4'b0000);
    exp3[0] = 4'b0001; exp3[1] = 4'b0000; exp3[2] = 4'b0001; exp3[3] = 4'b0000;
    S = 4'b0001; R = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sr_mode0", q[0], 4'b0000);
      chk("sr_mode1", q[1], 4'b0001);
      chk("sr_mode2_hold0", q[2], 4'b0000);
      chk("sr_mode3_toggle", q[3], exp3[k]);
    end
    S = 4'b0001; R = '0;
    tick();
    for (int m = 0; m < 4; m++) chk("preset_q", q[m], 4'b0001);
    S = 4'b0001; R = 4'b0001;
    tick();
    chk("sr2_mode0", q[0], 4'b0000);
    chk("sr2_mode1", q[1], 4'b0001);
    chk("sr2_mode2_hold1", q[2], 4'b0001);
    chk("sr2_mode3", q[3], 4'b0000);
    for (int m = 0; m < 4; m++) chk("sr2_conflict", cf[m], 4'b0001);

    // channel independence on the toggle-mode instance
    S = 4'b1001; R = '0;
    tick();
    chk("indep_pre", q[3], 4'b1001);
    expi[0] = 4'b1101; expi[1] = 4'b1001; expi[2] = 4'b1101; expi[3] = 4'b1001;
    S = 4'b0100; R = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("indep_q", q[3], expi[k]);
      chk("indep_qn", qn[3], ~expi[k]);
      chk("indep_hold", ha[3], 4'b0000);
    end
    chk("indep_conflict", cf[3], 4'b0101);
    S = '0; R = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 4; m++) chk("late_rst_q", q[m], 4'b0000);
    chk("late_rst_cf", cf[3], 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
